count_uart_tx: RTL and testbench

COUNT_UART_TX -- requirements
Module: count_uart_tx

---
 rtl/count_uart_tx_pkg.sv | 19 +
 rtl/uart_baud_div.sv | 31 +++
 rtl/count_uart_tx.sv | 95 +++++++++
 tb/tb_count_uart_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/count_uart_tx_pkg.sv
// Shared definitions for the count_uart_tx serial transmitter.
package count_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Clock cycles occupied by one complete frame at a given divider.
  function automatic int frame_cycles(input int div);
    return FRAME_BITS * div;
  endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Bit-period timer: counts 0..DIV-1 and strobes on the last cycle of each bit.
module uart_baud_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic bit_end,
  output logic pre_end
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Restart at frame accept so bit boundaries line up with the start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || (cnt == CW'(DIV - 1))) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // pre_end lets the caller register an output that lands on the last bit cycle.
  assign bit_end = (cnt == CW'(DIV - 1));
  assign pre_end = (cnt == CW'(DIV - 2));

endmodule

// File: rtl/count_uart_tx.sv
// 8N1 serial transmitter for the counter value; one byte per handshake.
//
// state | meaning
// IDLE  | line high, ready for a byte
// START | start bit (0) on the line
// DATA  | shifting out 8 data bits, LSB first
// STOP  | stop bit (1); done pulses on its last cycle
module count_uart_tx
  import count_uart_tx_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       accept;
  logic       bit_end;
  logic       pre_end;

  // Ready depends only on registered state, never on valid.
  assign ready  = (state == IDLE) && !rst;
  assign accept = valid && ready;

  uart_baud_div #(.DIV(DIV)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .bit_end(bit_end),
    .pre_end(pre_end)
  );

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= START;
            shreg   <= data;
            bit_idx <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end
        end
        STOP: begin
          if (pre_end) begin
            done <= 1'b1;
          end
          if (bit_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// Self-checking bench for count_uart_tx at DIV=4 with a tx-decoding scoreboard.
module tb_count_uart_tx;

  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  int n_cmp    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_frames = 0;

  logic [7:0] exp_q[$];
  logic [7:0] dec_q[$];
  int         start_q[$];

  count_uart_tx #(.DIV(DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .valid(valid),
    .ready(ready),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples every cycle of a frame, pops the expected byte.
  initial begin : mon
    logic [9:0] bits;
    logic [7:0] e;
    logic       abort;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) continue;
      start_q.push_back(cyc);
      abort = 1'b0;
      bits  = '0;
      for (int j = 0; j < FRAME; j++) begin
        if (j > 0) @(negedge clk);
        if (rst !== 1'b0) begin
          abort = 1'b1;
          break;
        end
        if (j % DIV == 0) begin
          bits[j / DIV] = tx;
        end else begin
          n_cmp++;
          if (tx !== bits[j / DIV]) begin
            n_err++;
            $display("FAIL bit_stable: bit %0d cycle %0d got %b held %b", j / DIV, cyc, tx, bits[j / DIV]);
          end
        end
      end
      if (!abort) begin
        n_frames++;
        n_cmp++;
        if (bits[9] !== 1'b1) begin
          n_err++;
          $display("FAIL stop_bit: got %b expected 1", bits[9]);
        end
        dec_q.push_back(bits[8:1]);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_frame: got %h expected no frame", bits[8:1]);
        end else begin
          e = exp_q.pop_front();
          if (bits[8:1] !== e) begin
            n_err++;
            $display("FAIL frame_byte: got %h expected %h", bits[8:1], e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) tick();
    n_cmp++; if (tx !== 1'b1)    begin n_err++; $display("FAIL rst_tx: got %b expected 1", tx); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b expected 0", ready); end
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL rst_done: got %b expected 0", done); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b expected 1", ready); end
    tick();
  endtask

  // One frame with cycle-exact checks of tx, busy, done and ready.
  task automatic test_single(input logic [7:0] b);
    int         k;
    logic [9:0] fr;
    logic       exp_tx;
    fr = {1'b1, b, 1'b0};
    start_q.delete();
    data  = b;
    valid = 1'b1;
    k     = cyc + 1;
    exp_q.push_back(b);
    tick();
    valid = 1'b0;
    data  = ~b;
    for (int rel = 0; rel < FRAME + 4; rel++) begin
      @(negedge clk);
      exp_tx = (rel < FRAME) ? fr[rel / DIV] : 1'b1;
      n_cmp++; if (tx !== exp_tx) begin n_err++; $display("FAIL single_tx: rel %0d got %b expected %b", rel, tx, exp_tx); end
      n_cmp++; if (busy !== (rel < FRAME)) begin n_err++; $display("FAIL single_busy: rel %0d got %b expected %b", rel, busy, rel < FRAME); end
      n_cmp++; if (done !== (rel == FRAME - 1)) begin n_err++; $display("FAIL single_done: rel %0d got %b expected %b", rel, done, rel == FRAME - 1); end
      n_cmp++; if (ready !== (rel >= FRAME)) begin n_err++; $display("FAIL single_ready: rel %0d got %b expected %b", rel, ready, rel >= FRAME); end
    end
    n_cmp++;
    if (start_q.size() != 1 || start_q[0] != k) begin
      n_err++;
      $display("FAIL single_start: got %0d starts first at %0d expected 1 start at %0d", start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, k);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL single_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b);
    int k;
    start_q.delete();
    data  = a;
    valid = 1'b1;
    k     = cyc + 1;
    exp_q.push_back(a);
    exp_q.push_back(b);
    tick();
    data = b;
    repeat (40) tick();
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_back: got %b expected 1", ready); end
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL b2b_gap_busy: got %b expected 0", busy); end
    tick();
    valid = 1'b0;
    n_cmp++; if (busy !== 1'b1)  begin n_err++; $display("FAIL b2b_second_busy: got %b expected 1", busy); end
    repeat (FRAME + 3) @(negedge clk);
    n_cmp++;
    if (start_q.size() != 2) begin
      n_err++;
      $display("FAIL b2b_frames: got %0d starts expected 2", start_q.size());
    end else begin
      n_cmp++; if (start_q[0] != k)      begin n_err++; $display("FAIL b2b_start1: got %0d expected %0d", start_q[0], k); end
      n_cmp++; if (start_q[1] != k + 41) begin n_err++; $display("FAIL b2b_start2: got %0d expected %0d", start_q[1], k + 41); end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_ignore_midframe(input logic [7:0] b);
    int f0;
    start_q.delete();
    f0    = n_frames;
    data  = b;
    valid = 1'b1;
    exp_q.push_back(b);
    tick();
    valid = 1'b0;
    repeat (10) tick();
    data  = 8'hFF;
    valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %b expected 0", ready); end
    tick();
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL mid_ready_after: got %b expected 0", ready); end
    valid = 1'b0;
    data  = 8'h00;
    repeat (FRAME + 10) @(negedge clk);
    n_cmp++; if (n_frames != f0 + 1)   begin n_err++; $display("FAIL mid_frames: got %0d expected %0d", n_frames - f0, 1); end
    n_cmp++; if (start_q.size() != 1)  begin n_err++; $display("FAIL mid_starts: got %0d expected 1", start_q.size()); end
    n_cmp++; if (exp_q.size() != 0)    begin n_err++; $display("FAIL mid_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    data  = 8'hC3;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (17) tick();
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL rmid_pre_tx: got %b expected 0", tx); end
    rst = 1'b1;
    #1;
    n_cmp++; if (tx !== 1'b1)    begin n_err++; $display("FAIL rmid_tx: got %b expected 1", tx); end
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready: got %b expected 0", ready); end
    n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL rmid_done: got %b expected 0", done); end
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rmid_release_ready: got %b expected 1", ready); end
    test_single(8'h00);
  endtask

  task automatic test_counter();
    logic [7:0] d;
    start_q.delete();
    dec_q.delete();
    d     = 8'hF0;
    data  = d;
    valid = 1'b1;
    for (int m = 0; m < 6; m++) begin
      exp_q.push_back(d);
      d = d + 8'd41;
    end
    for (int n = 0; n < 206; n++) begin
      tick();
      data = data + 8'd1;
      if (n == 205) valid = 1'b0;
    end
    repeat (FRAME + 5) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL cnt_drain: got %0d pending expected 0", exp_q.size()); end
    n_cmp++;
    if (dec_q.size() != 6) begin
      n_err++;
      $display("FAIL cnt_frames: got %0d expected 6", dec_q.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        n_cmp++;
        if (dec_q[i] !== 8'(dec_q[i-1] + 8'd41)) begin
          n_err++;
          $display("FAIL cnt_step: idx %0d got %h expected %h", i, dec_q[i], 8'(dec_q[i-1] + 8'd41));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(8'h55);
    test_single(8'hA3);
    test_back_to_back(8'hA5, 8'h3C);
    test_ignore_midframe(8'h96);
    test_reset_midframe();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
